mem_arbiter: RTL and testbench

- Sequences the single shared main-memory port between the I-cache and D-cache.
- Serves three request types, one at a time:
  - I-cache block fills.
  - D-cache block fills.
  - D-cache write-through stores.
- Sits between both cache controllers and the multi-cycle memory model. The pipeline stalls on the `busy`/`*_done` handshakes.

---
 rtl/mem_pkg.sv | 18 +
 rtl/word_counter.sv | 39 +++
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: types and constants shared by the memory arbiter and its counter.
//   state_e   - arbiter FSM states
//   BLK_BYTES - bytes per cache block
//   BLK_OFF_W - byte-offset bits inside a block (cleared to form a fill base)
package mem_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      FILL_I,
      FILL_D,
      DONE
   } state_e;

   localparam int BLK_BYTES = 16;
   localparam int BLK_OFF_W = 4;

endpackage

// File: rtl/word_counter.sv
// word_counter: 3-bit up-counter with synchronous clear, count enable and a
// terminal flag that is high while the count sits at its last value (7).
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous clear (wins over en)
//   en          increment enable
//   cnt         current count
//   term        cnt == 7
module word_counter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   output logic [2:0] cnt,
   output logic       term
);

   logic [2:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = 3'd0;
      end else if (en) begin
         cnt_d = cnt_q + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 3'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign term = (cnt_q == 3'd7);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences the single main-memory port between I-cache fills,
// D-cache fills and D-cache write-through stores, one transaction at a time.
//   i_miss/i_miss_addr          I-cache fill request (level)
//   d_miss/d_miss_addr          D-cache fill request (level)
//   d_wr_req/d_wr_addr/d_wr_data store write-through request (level)
//   mem_data_valid/mem_rdata    read data returning from memory
//   mem_en/mem_wr/mem_addr/mem_wdata  memory command port
//   fill_sel_d/fill_we/fill_word/fill_data/fill_tag_we  cache fill port
//   i_done/d_done/d_wr_ack      one-cycle completion pulses
//   busy                        high whenever a transaction is in progress
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int BLK_WORDS = 8,
   parameter int MEM_LAT   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_miss,
   input  logic [ADDR_W-1:0] i_miss_addr,
   input  logic              d_miss,
   input  logic [ADDR_W-1:0] d_miss_addr,
   input  logic              d_wr_req,
   input  logic [ADDR_W-1:0] d_wr_addr,
   input  logic [DATA_W-1:0] d_wr_data,
   input  logic              mem_data_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              fill_sel_d,
   output logic              fill_we,
   output logic [2:0]        fill_word,
   output logic [DATA_W-1:0] fill_data,
   output logic              fill_tag_we,
   output logic              i_done,
   output logic              d_done,
   output logic              d_wr_ack,
   output logic              busy
);

   // The counters and block-offset math assume 8 x 16-bit words per block;
   // latency only affects when data returns, which the receive side tracks.
   if (BLK_WORDS != 8 || BLK_WORDS * (DATA_W / 8) != BLK_BYTES ||
       MEM_LAT < 1 || ADDR_W <= BLK_OFF_W) begin : g_bad_cfg
      $error("mem_arbiter: unsupported parameter combination");
   end

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              sel_d_q, sel_d_d;
   logic              issue_done_q, issue_done_d;

   logic [2:0] icnt, rcnt;
   logic       icnt_term, rcnt_term;
   logic       in_fill, issue_en, recv_en, cnt_clr;

   assign in_fill  = (state_q == FILL_I) || (state_q == FILL_D);
   // All 8 reads are issued back-to-back; the sticky flag stops issuing once
   // the 3-bit issue counter has wrapped past its last word.
   assign issue_en = in_fill && !issue_done_q;
   // Valid data outside a fill is stray and must never reach a cache.
   assign recv_en  = in_fill && mem_data_valid;
   assign cnt_clr  = (state_q == IDLE);

   word_counter u_issue_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (issue_en),
      .cnt   (icnt),
      .term  (icnt_term)
   );

   word_counter u_recv_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (recv_en),
      .cnt   (rcnt),
      .term  (rcnt_term)
   );

   // State register and transaction latches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         data_q       <= '0;
         sel_d_q      <= 1'b0;
         issue_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         sel_d_q      <= sel_d_d;
         issue_done_q <= issue_done_d;
      end
   end

   // Next-state logic; the D side wins because it is older in the pipeline
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      data_d       = data_q;
      sel_d_d      = sel_d_q;
      issue_done_d = issue_done_q | (issue_en & icnt_term);
      case (state_q)
         IDLE: begin
            issue_done_d = 1'b0;
            if (d_wr_req) begin
               state_d = WRITE;
               addr_d  = d_wr_addr;
               data_d  = d_wr_data;
               sel_d_d = 1'b1;
            end else if (d_miss) begin
               state_d = FILL_D;
               addr_d  = {d_miss_addr[ADDR_W-1:BLK_OFF_W], {BLK_OFF_W{1'b0}}};
               sel_d_d = 1'b1;
            end else if (i_miss) begin
               state_d = FILL_I;
               addr_d  = {i_miss_addr[ADDR_W-1:BLK_OFF_W], {BLK_OFF_W{1'b0}}};
               sel_d_d = 1'b0;
            end
         end
         WRITE: state_d = IDLE;
         FILL_I, FILL_D: begin
            if (recv_en && rcnt_term) begin
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      mem_en      = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      fill_we     = 1'b0;
      fill_word   = 3'd0;
      fill_tag_we = 1'b0;
      i_done      = 1'b0;
      d_done      = 1'b0;
      d_wr_ack    = 1'b0;
      case (state_q)
         WRITE: begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = data_q;
            d_wr_ack  = 1'b1;
         end
         FILL_I, FILL_D: begin
            if (issue_en) begin
               mem_en   = 1'b1;
               // Base is block-aligned, so the word offset never carries.
               mem_addr = addr_q + ADDR_W'({icnt, 1'b0});
            end
            fill_we     = recv_en;
            fill_word   = recv_en ? rcnt : 3'd0;
            fill_tag_we = recv_en && rcnt_term;
         end
         DONE: begin
            i_done = !sel_d_q;
            d_done = sel_d_q;
         end
         default: ;
      endcase
   end

   assign fill_sel_d = sel_d_q;
   assign fill_data  = mem_rdata;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int K_WR = 0;
   localparam int K_FI = 1;
   localparam int K_FD = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_miss = 1'b0, d_miss = 1'b0, d_wr_req = 1'b0;
   logic [AW-1:0] i_miss_addr = '0, d_miss_addr = '0, d_wr_addr = '0;
   logic [DW-1:0] d_wr_data = '0;
   logic          mem_data_valid = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_en, mem_wr, fill_sel_d, fill_we, fill_tag_we;
   logic          i_done, d_done, d_wr_ack, busy;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, fill_data;
   logic [2:0]    fill_word;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BLK_WORDS(8), .MEM_LAT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_miss(i_miss), .i_miss_addr(i_miss_addr),
      .d_miss(d_miss), .d_miss_addr(d_miss_addr),
      .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
      .mem_data_valid(mem_data_valid), .mem_rdata(mem_rdata),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .fill_sel_d(fill_sel_d), .fill_we(fill_we), .fill_word(fill_word),
      .fill_data(fill_data), .fill_tag_we(fill_tag_we),
      .i_done(i_done), .d_done(d_done), .d_wr_ack(d_wr_ack), .busy(busy)
   );

   int cyc = 0;
   int n_cmp = 0;
   int n_err = 0;

   function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
      return a ^ 16'h5A5A;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
      end
   endtask

   // ---------------- memory model: fixed 4-cycle read latency ----------------
   typedef struct {int due; logic [AW-1:0] addr;} rd_t;
   rd_t  rdq[$];
   logic inj_valid = 1'b0;

   initial begin : mem_drv
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         mem_data_valid = 1'b0;
         mem_rdata      = '0;
         if (rdq.size() > 0 && rdq[0].due == cyc) begin
            mem_data_valid = 1'b1;
            mem_rdata      = mdata(rdq[0].addr);
            void'(rdq.pop_front());
         end else if (inj_valid) begin
            mem_data_valid = 1'b1;
            mem_rdata      = 16'hDEAD;
         end
      end
   end

   // ---------------- event log for literal checks ----------------
   int            first_rd_cyc, tag_cyc, idone_cyc, ddone_cyc, wr_cyc, n_we;
   logic [AW-1:0] first_rd_addr, last_rd_addr, min_rd, wr_addr;
   logic [DW-1:0] wr_data, word0_data;
   bit            rd_seen;

   task automatic log_clear();
      first_rd_cyc = -1; tag_cyc = -1; idone_cyc = -1; ddone_cyc = -1; wr_cyc = -1;
      n_we = 0; rd_seen = 0; first_rd_addr = '0; last_rd_addr = '0; min_rd = 16'hFFFF;
      wr_addr = '0; wr_data = '0; word0_data = '0;
   endtask

   // ---------------- transaction-level model + per-cycle compare ----------------
   bit            m_act = 0;
   int            m_t0 = 0, m_kind = 0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_data = '0;

   initial begin : cmp
      logic          e_busy, e_en, e_wr, e_we, e_tag, e_id, e_dd, e_ack, e_sel;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata, e_fdata;
      logic [2:0]    e_word;
      bit            was_idle, end_now;
      int            rel;
      forever begin
         @(negedge clk);
         e_busy = 0; e_en = 0; e_wr = 0; e_we = 0; e_tag = 0; e_id = 0; e_dd = 0;
         e_ack = 0; e_sel = 0; e_addr = '0; e_wdata = '0; e_fdata = '0; e_word = '0;
         was_idle = !m_act;
         end_now  = 0;
         if (!rst_n) begin
            m_act = 0;
         end else if (m_act) begin
            rel   = cyc - m_t0;
            e_sel = (m_kind != K_FI);
            if (m_kind == K_WR) begin
               e_busy = 1; e_en = 1; e_wr = 1; e_addr = m_addr; e_wdata = m_data; e_ack = 1;
               end_now = 1;
            end else begin
               e_busy = 1;
               if (rel <= 8) begin
                  e_en   = 1;
                  e_addr = AW'(int'(m_addr) + 2 * (rel - 1));
               end
               if (rel >= 5 && rel <= 12) begin
                  e_we    = 1;
                  e_word  = 3'(rel - 5);
                  e_fdata = mdata(AW'(int'(m_addr) + 2 * (rel - 5)));
               end
               e_tag = (rel == 12);
               if (rel == 13) begin
                  e_id = (m_kind == K_FI);
                  e_dd = (m_kind == K_FD);
                  end_now = 1;
               end
            end
         end
         chk("busy", busy, e_busy);
         chk("mem_en", mem_en, e_en);
         chk("mem_wr", mem_wr, e_wr);
         chk("mem_addr", mem_addr, e_addr);
         chk("mem_wdata", mem_wdata, e_wdata);
         chk("fill_we", fill_we, e_we);
         chk("fill_tag_we", fill_tag_we, e_tag);
         chk("i_done", i_done, e_id);
         chk("d_done", d_done, e_dd);
         chk("d_wr_ack", d_wr_ack, e_ack);
         if (e_we) begin
            chk("fill_word", fill_word, e_word);
            chk("fill_data", fill_data, e_fdata);
         end
         if (e_we || e_id || e_dd) chk("fill_sel_d", fill_sel_d, e_sel);
         if (end_now) m_act = 0;
         // log what the DUT actually did
         if (mem_en && !mem_wr) begin
            if (!rd_seen) begin
               first_rd_addr = mem_addr; first_rd_cyc = cyc; rd_seen = 1;
            end
            last_rd_addr = mem_addr;
            if (mem_addr < min_rd) min_rd = mem_addr;
            rdq.push_back('{cyc + 4, mem_addr});
         end
         if (mem_en && mem_wr) begin
            wr_cyc = cyc; wr_addr = mem_addr; wr_data = mem_wdata;
         end
         if (fill_we) begin
            if (fill_word == 3'd0) word0_data = fill_data;
            n_we++;
         end
         if (fill_tag_we) tag_cyc = cyc;
         if (i_done) idone_cyc = cyc;
         if (d_done) ddone_cyc = cyc;
         // acceptance of a new request by the model
         if (rst_n && was_idle) begin
            if (d_wr_req) begin
               m_act = 1; m_kind = K_WR; m_addr = d_wr_addr; m_data = d_wr_data; m_t0 = cyc;
            end else if (d_miss) begin
               m_act = 1; m_kind = K_FD; m_addr = d_miss_addr & 16'hFFF0; m_t0 = cyc;
            end else if (i_miss) begin
               m_act = 1; m_kind = K_FI; m_addr = i_miss_addr & 16'hFFF0; m_t0 = cyc;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_pulse(input int which, input string nm);
      bit seen = 0;
      for (int k = 0; k < 60 && !seen; k++) begin
         @(negedge clk);
         #1;
         case (which)
            0:       seen = i_done;
            1:       seen = d_done;
            default: seen = d_wr_ack;
         endcase
      end
      if (!seen) begin
         n_cmp++; n_err++;
         $display("FAIL timeout_%s cyc=%0d got=no_pulse expected=pulse", nm, cyc);
      end
      @(posedge clk);
      #2;
   endtask

   task automatic wait_we(input int n);
      bit ok = 0;
      for (int k = 0; k < 60 && !ok; k++) begin
         @(posedge clk);
         #2;
         ok = (n_we >= n);
      end
      if (!ok) begin
         n_cmp++; n_err++;
         $display("FAIL timeout_fill_we cyc=%0d got=%0d expected=%0d", cyc, n_we, n);
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin : stim
      int acc;
      log_clear();
      cycles(3);
      chk("rst_busy", busy, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_fill_sel_d", fill_sel_d, 0);
      rst_n = 1'b1;
      cycles(2);

      // single I-miss at 0x1236
      log_clear();
      i_miss = 1; i_miss_addr = 16'h1236; acc = cyc;
      wait_pulse(0, "i_done_t1");
      i_miss = 0;
      chk("t1_first_addr", first_rd_addr, 16'h1230);
      chk("t1_first_cyc", first_rd_cyc, acc + 1);
      chk("t1_last_addr", last_rd_addr, 16'h123E);
      chk("t1_word0_data", word0_data, 16'h486A);
      chk("t1_tag_cyc", tag_cyc, acc + 12);
      chk("t1_idone_cyc", idone_cyc, acc + 13);
      chk("t1_n_we", n_we, 8);
      cycles(2);

      // simultaneous I and D misses: D first, then I with no gap
      log_clear();
      d_miss = 1; d_miss_addr = 16'h2468; i_miss = 1; i_miss_addr = 16'h1000; acc = cyc;
      wait_pulse(1, "d_done_t2");
      d_miss = 0;
      chk("t2_ddone_cyc", ddone_cyc, acc + 13);
      log_clear();
      wait_pulse(0, "i_done_t2");
      i_miss = 0;
      chk("t2_i_first_cyc", first_rd_cyc, acc + 15);
      chk("t2_i_first_addr", first_rd_addr, 16'h1000);
      chk("t2_idone_cyc", idone_cyc, acc + 27);
      cycles(2);

      // store beats a concurrent D-miss
      log_clear();
      d_wr_req = 1; d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF;
      d_miss = 1; d_miss_addr = 16'h0052; acc = cyc;
      wait_pulse(2, "ack_t3");
      d_wr_req = 0;
      chk("t3_wr_cyc", wr_cyc, acc + 1);
      chk("t3_wr_addr", wr_addr, 16'h0040);
      chk("t3_wr_data", wr_data, 16'hBEEF);
      wait_pulse(1, "d_done_t3");
      d_miss = 0;
      chk("t3_fill_first_addr", first_rd_addr, 16'h0050);
      chk("t3_fill_first_cyc", first_rd_cyc, acc + 3);
      chk("t3_ddone_cyc", ddone_cyc, acc + 15);
      cycles(2);

      // D-miss dropped after 3 words
      log_clear();
      d_miss = 1; d_miss_addr = 16'h3010;
      wait_we(3);
      d_miss = 0;
      wait_pulse(1, "d_done_t4");
      chk("t4_n_we", n_we, 8);
      cycles(2);

      // reset in the middle of a fill, then stale/stray valid data
      log_clear();
      i_miss = 1; i_miss_addr = 16'h4000;
      wait_we(4);
      rst_n = 0; i_miss = 0;
      #1;
      chk("t5_busy", busy, 0);
      chk("t5_mem_en", mem_en, 0);
      chk("t5_fill_we", fill_we, 0);
      chk("t5_fill_sel_d", fill_sel_d, 0);
      cycles(2);
      rst_n = 1;
      cycles(8);
      inj_valid = 1;
      cycles(1);
      inj_valid = 0;
      cycles(3);
      chk("t5_n_we", n_we, 4);
      chk("t5_no_done", idone_cyc, -1);

      // fill at the top of the address space
      log_clear();
      d_miss = 1; d_miss_addr = 16'hFFF8;
      wait_pulse(1, "d_done_t6");
      d_miss = 0;
      chk("t6_first_addr", first_rd_addr, 16'hFFF0);
      chk("t6_last_addr", last_rd_addr, 16'hFFFE);
      chk("t6_min_addr", min_rd, 16'hFFF0);
      cycles(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
